// File: rtl/timer_event_logger_if.sv
// Timer-side handshake and host-side event FIFO signals of the timer event logger.
interface timer_event_logger_if;
    logic       counting;
    logic [3:0] count;
    logic       done;
    logic       ack;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_data;
    logic [2:0] fifo_level;
    logic [7:0] event_cnt;

    modport master (
        output counting, count, done, evt_ready,
        input  ack, evt_valid, evt_data, fifo_level, event_cnt
    );

    modport slave (
        input  counting, count, done, evt_ready,
        output ack, evt_valid, evt_data, fifo_level, event_cnt
    );
endinterface

// File: rtl/timer_event_logger.sv
// Logs each completed upstream timer run as {sequence, captured delay} into a
// 4-entry first-word-fall-through FIFO and acknowledges the timer with a one-cycle pulse.
module timer_event_logger (
    input logic           clk,
    input logic           reset,
    timer_event_logger_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PUSH = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t     state_r;
    logic       ack_r;
    logic [3:0] delay_r;
    logic [3:0] seq_r;
    logic [7:0] event_cnt_r;
    logic [7:0] mem_r [0:3];
    logic [1:0] wr_ptr_r;
    logic [1:0] rd_ptr_r;
    logic [2:0] level_r;
    logic       wr_en_s;
    logic       rd_en_s;
    logic       valid_s;

    // Full check uses the level at the start of the cycle, so a same-cycle read never frees a slot.
    assign wr_en_s = (state_r == PUSH) && (level_r < 3'd4);
    assign valid_s = (level_r != 3'd0);
    assign rd_en_s = valid_s && bus.evt_ready;

    // Control FSM with registered acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            delay_r <= 4'd0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.counting) begin
                        delay_r <= bus.count;
                        state_r <= RUN;
                    end else if (bus.done) begin
                        delay_r <= 4'd0;
                        state_r <= PUSH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.done) begin
                        state_r <= PUSH;
                    end else if (!bus.counting) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                PUSH: begin
                    if (wr_en_s) begin
                        ack_r   <= 1'b1;
                        state_r <= ACK;
                    end else begin
                        state_r <= PUSH;
                    end
                end
                ACK: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Event FIFO storage, pointers, sequence number and saturating event counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            seq_r       <= 4'd0;
            event_cnt_r <= 8'd0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= {seq_r, delay_r};
                wr_ptr_r        <= wr_ptr_r + 2'd1;
                seq_r           <= seq_r + 4'd1;
                if (event_cnt_r != 8'hFF) begin
                    event_cnt_r <= event_cnt_r + 8'd1;
                end else begin
                    event_cnt_r <= event_cnt_r;
                end
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy: a simultaneous write and read leaves the level unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_r <= 3'd0;
        end else begin
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + 3'd1;
                2'b01:   level_r <= level_r - 3'd1;
                default: level_r <= level_r;
            endcase
        end
    end

    assign bus.ack        = ack_r;
    assign bus.evt_valid  = valid_s;
    assign bus.evt_data   = valid_s ? mem_r[rd_ptr_r] : 8'h00;
    assign bus.fifo_level = level_r;
    assign bus.event_cnt  = event_cnt_r;

endmodule

// File: tb/tb_timer_event_logger.sv
// Directed self-checking bench for timer_event_logger; inputs change and outputs are sampled on the falling edge.
module tb_timer_event_logger;

    logic clk;
    logic reset;
    int   checks;
    int   passes;
    int   ack_seen;

    timer_event_logger_if bus ();

    timer_event_logger dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count ack pulses as they end.
    always @(posedge clk) begin
        if (bus.ack === 1'b1) ack_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        bus.counting  = 1'b0;
        bus.count     = 4'h0;
        bus.done      = 1'b0;
        bus.evt_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Runs one counting->done sequence; returns at the falling edge after the ack, or with done still held.
    task automatic log_event(input logic [3:0] c, output bit got, output logic [7:0] d);
        got = 1'b0;
        d   = 8'h00;
        bus.counting = 1'b1;
        bus.count    = c;
        @(negedge clk);
        bus.done     = 1'b1;
        bus.counting = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin
                got = 1'b1;
                d   = bus.evt_data;
                break;
            end
        end
        if (got) begin
            bus.done = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.counting = 1'b0; bus.count = 4'h0; bus.done = 1'b0; bus.evt_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (bus.ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.ack); else passes++;
        checks++; if (bus.evt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.evt_valid); else passes++;
        checks++; if (bus.evt_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.evt_data); else passes++;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", bus.fifo_level); else passes++;
        checks++; if (bus.event_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", bus.event_cnt); else passes++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) $display("FAIL reset_idle_ack: got %b want 0", bus.ack); else passes++;
    endtask

    task automatic test_basic();
        apply_reset();
        bus.counting = 1'b1; bus.count = 4'h5;
        @(negedge clk);
        bus.done = 1'b1; bus.count = 4'hA;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) $display("FAIL basic_push_ack: got %b want 0", bus.ack); else passes++;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) $display("FAIL basic_ack: got %b want 1", bus.ack); else passes++;
        checks++; if (bus.evt_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", bus.evt_valid); else passes++;
        checks++; if (bus.evt_data !== 8'h05) $display("FAIL basic_data: got %h want 05", bus.evt_data); else passes++;
        checks++; if (bus.fifo_level !== 3'd1) $display("FAIL basic_level: got %0d want 1", bus.fifo_level); else passes++;
        checks++; if (bus.event_cnt !== 8'd1) $display("FAIL basic_cnt: got %0d want 1", bus.event_cnt); else passes++;
        bus.done = 1'b0; bus.counting = 1'b0;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) $display("FAIL basic_ack_one_cycle: got %b want 0", bus.ack); else passes++;
        bus.evt_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL basic_read_level: got %0d want 0", bus.fifo_level); else passes++;
        checks++; if (bus.evt_data !== 8'h00) $display("FAIL basic_empty_data: got %h want 00", bus.evt_data); else passes++;
        @(negedge clk);
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL basic_underflow: got %0d want 0", bus.fifo_level); else passes++;
        bus.evt_ready = 1'b0;
    endtask

    task automatic test_orphan();
        int a0;
        apply_reset();
        a0 = ack_seen;
        bus.done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) $display("FAIL orphan_ack: got %b want 1", bus.ack); else passes++;
        checks++; if (bus.evt_data !== 8'h00) $display("FAIL orphan_data: got %h want 00", bus.evt_data); else passes++;
        checks++; if (bus.fifo_level !== 3'd1) $display("FAIL orphan_level: got %0d want 1", bus.fifo_level); else passes++;
        bus.done = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ack_seen - a0 !== 1) $display("FAIL orphan_ack_count: got %0d want 1", ack_seen - a0); else passes++;
    endtask

    task automatic test_abort();
        int a0;
        apply_reset();
        a0 = ack_seen;
        bus.counting = 1'b1; bus.count = 4'h7;
        @(negedge clk);
        bus.counting = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL abort_level: got %0d want 0", bus.fifo_level); else passes++;
        checks++; if (ack_seen !== a0) $display("FAIL abort_no_ack: got %0d want %0d", ack_seen, a0); else passes++;
        bus.done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) $display("FAIL abort_then_done_ack: got %b want 1", bus.ack); else passes++;
        checks++; if (bus.evt_data !== 8'h00) $display("FAIL abort_then_done_data: got %h want 00", bus.evt_data); else passes++;
        bus.done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit         got;
        logic [7:0] d;
        int         a0;
        int         miss;
        logic [7:0] exp_t [0:3];
        exp_t[0] = 8'h12; exp_t[1] = 8'h23; exp_t[2] = 8'h34; exp_t[3] = 8'h45;
        apply_reset();
        miss = 0;
        for (int n = 1; n <= 4; n++) begin
            log_event(4'(n), got, d);
            if (!got) miss++;
        end
        checks++; if (miss !== 0) $display("FAIL bp_fill_acks: got %0d missing want 0", miss); else passes++;
        checks++; if (bus.fifo_level !== 3'd4) $display("FAIL bp_full_level: got %0d want 4", bus.fifo_level); else passes++;
        checks++; if (bus.evt_data !== 8'h01) $display("FAIL bp_head: got %h want 01", bus.evt_data); else passes++;
        a0 = ack_seen;
        bus.counting = 1'b1; bus.count = 4'h5;
        @(negedge clk);
        bus.done = 1'b1; bus.counting = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (ack_seen !== a0) $display("FAIL bp_no_ack_when_full: got %0d want %0d", ack_seen, a0); else passes++;
        checks++; if (bus.fifo_level !== 3'd4) $display("FAIL bp_level_held: got %0d want 4", bus.fifo_level); else passes++;
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        checks++; if (bus.fifo_level !== 3'd3) $display("FAIL bp_preread_full: got %0d want 3", bus.fifo_level); else passes++;
        checks++; if (bus.evt_data !== 8'h12) $display("FAIL bp_head_after_read: got %h want 12", bus.evt_data); else passes++;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) $display("FAIL bp_ack_after_read: got %b want 1", bus.ack); else passes++;
        checks++; if (bus.fifo_level !== 3'd4) $display("FAIL bp_refilled: got %0d want 4", bus.fifo_level); else passes++;
        bus.done = 1'b0;
        @(negedge clk);
        bus.evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.evt_data !== exp_t[k]) $display("FAIL bp_order_%0d: got %h want %h", k, bus.evt_data, exp_t[k]); else passes++;
            @(negedge clk);
        end
        bus.evt_ready = 1'b0;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL bp_drained: got %0d want 0", bus.fifo_level); else passes++;
        checks++; if (ack_seen - a0 !== 1) $display("FAIL bp_single_ack: got %0d want 1", ack_seen - a0); else passes++;
    endtask

    task automatic test_back_to_back();
        bit         got;
        logic [7:0] d;
        apply_reset();
        log_event(4'h6, got, d);
        checks++; if (bus.evt_data !== 8'h06) $display("FAIL b2b_first: got %h want 06", bus.evt_data); else passes++;
        bus.counting = 1'b1; bus.count = 4'h7;
        @(negedge clk);
        bus.done = 1'b1; bus.counting = 1'b0;
        @(negedge clk);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        checks++; if (bus.ack !== 1'b1) $display("FAIL b2b_ack: got %b want 1", bus.ack); else passes++;
        checks++; if (bus.fifo_level !== 3'd1) $display("FAIL b2b_level: got %0d want 1", bus.fifo_level); else passes++;
        checks++; if (bus.evt_data !== 8'h17) $display("FAIL b2b_order: got %h want 17", bus.evt_data); else passes++;
        bus.done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap_saturate();
        bit         got;
        logic [7:0] d;
        int         miss;
        apply_reset();
        bus.evt_ready = 1'b1;
        miss = 0;
        for (int n = 1; n <= 260; n++) begin
            log_event(4'(n), got, d);
            if (!got) miss++;
            if (n == 16) begin
                checks++; if (d !== 8'hF0) $display("FAIL wrap_seq15: got %h want f0", d); else passes++;
            end
            if (n == 17) begin
                checks++; if (d !== 8'h01) $display("FAIL wrap_seq0: got %h want 01", d); else passes++;
            end
            if (n == 254) begin
                checks++; if (bus.event_cnt !== 8'd254) $display("FAIL cnt_254: got %0d want 254", bus.event_cnt); else passes++;
            end
        end
        bus.evt_ready = 1'b0;
        checks++; if (miss !== 0) $display("FAIL wrap_acks: got %0d missing want 0", miss); else passes++;
        checks++; if (bus.event_cnt !== 8'd255) $display("FAIL cnt_saturate: got %0d want 255", bus.event_cnt); else passes++;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL wrap_level: got %0d want 0", bus.fifo_level); else passes++;
    endtask

    task automatic test_reset_mid();
        bit         got;
        logic [7:0] d;
        int         a0;
        apply_reset();
        for (int n = 1; n <= 4; n++) log_event(4'(n + 8), got, d);
        bus.counting = 1'b1; bus.count = 4'h3;
        @(negedge clk);
        bus.done = 1'b1; bus.counting = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        bus.done = 1'b0;
        #1;
        checks++; if (bus.ack !== 1'b0) $display("FAIL mid_reset_ack: got %b want 0", bus.ack); else passes++;
        checks++; if (bus.evt_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", bus.evt_valid); else passes++;
        checks++; if (bus.evt_data !== 8'h00) $display("FAIL mid_reset_data: got %h want 00", bus.evt_data); else passes++;
        checks++; if (bus.fifo_level !== 3'd0) $display("FAIL mid_reset_level: got %0d want 0", bus.fifo_level); else passes++;
        checks++; if (bus.event_cnt !== 8'd0) $display("FAIL mid_reset_cnt: got %0d want 0", bus.event_cnt); else passes++;
        @(negedge clk);
        reset = 1'b1;
        a0 = ack_seen;
        repeat (5) @(negedge clk);
        checks++; if (ack_seen !== a0) $display("FAIL mid_reset_no_ack: got %0d want %0d", ack_seen, a0); else passes++;
        bus.done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) $display("FAIL mid_reset_new_ack: got %b want 1", bus.ack); else passes++;
        checks++; if (bus.evt_data !== 8'h00) $display("FAIL mid_reset_new_data: got %h want 00", bus.evt_data); else passes++;
        bus.done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        checks = 0;
        passes = 0;
        ack_seen = 0;
        bus.counting = 1'b0; bus.count = 4'h0; bus.done = 1'b0; bus.evt_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_orphan();
        test_abort();
        test_backpressure();
        test_back_to_back();
        test_wrap_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
